// File: rtl/vc_rr_scheduler.sv
// vc_rr_scheduler: merges four class FIFOs into one sink, round-robin, with pop/capture/push sequencing.
// Latency: grant->pop 1 cycle, pop->push 2 cycles, 4 cycles per word; sink almost-full blocks new grants. Option: WEIGHTED_RR_EN.
module vc_rr_scheduler #(
  parameter int LINE_SIZE  = 12,
  parameter int CLASS_BITS = 2,
  parameter int BURST_MAX  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             almost_empty_signal,
  input  logic [4*LINE_SIZE-1:0] data_in,
  input  logic                   almost_full_signal,
  output logic [3:0]             pop_signal,
  output logic                   push_signal,
  output logic [LINE_SIZE-1:0]   data_out,
  output logic [1:0]             grant,
  output logic                   class_err
);

  typedef enum logic [1:0] {IDLE, POP, CAPTURE, PUSH} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             pop_q, pop_d;
  logic                   push_q, push_d;
  logic [LINE_SIZE-1:0]   data_q, data_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             last_q, last_d;
  logic                   err_q, err_d;

  logic [3:0]             elig;
  logic [1:0]             rr_pick;
  logic [1:0]             scan_idx;
  logic                   found;
  logic [1:0]             next_g;
  logic [LINE_SIZE-1:0]   sel_word;

  assign elig = ~almost_empty_signal;

`ifdef WEIGHTED_RR_EN
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [BW-1:0] burst_q, burst_d;
  logic          hold;
  // A zero count means no source owns the burst yet, so reset starts at source 0.
  assign hold = (burst_q != '0) && (int'(burst_q) < BURST_MAX) && elig[last_q];
`endif

  always_comb begin
    rr_pick  = last_q;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!found && elig[scan_idx]) begin
        rr_pick = scan_idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q == 2'(i)) sel_word = data_in[i*LINE_SIZE +: LINE_SIZE];
    end
  end

  always_comb begin
    state_d = state_q;
    pop_d   = pop_q;
    push_d  = push_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q;
    next_g  = rr_pick;
`ifdef WEIGHTED_RR_EN
    burst_d = burst_q;
`endif
    case (state_q)
      IDLE: begin
        pop_d  = '0;
        push_d = 1'b0;
        if (!almost_full_signal && (|elig)) begin
`ifdef WEIGHTED_RR_EN
          if (hold) begin
            next_g  = last_q;
            burst_d = burst_q + BW'(1);
          end else begin
            next_g  = rr_pick;
            burst_d = BW'(1);
          end
`endif
          pop_d   = 4'b0001 << next_g;
          grant_d = next_g;
          last_d  = next_g;
          state_d = POP;
        end
      end
      POP: begin
        pop_d   = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Source read latency is one cycle, so the popped word is on data_in now.
        data_d  = sel_word;
        push_d  = 1'b1;
        if (sel_word[LINE_SIZE-1 -: CLASS_BITS] != CLASS_BITS'(grant_q)) err_d = 1'b1;
        state_d = PUSH;
      end
      PUSH: begin
        push_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pop_q   <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= 2'd3;
      err_q   <= 1'b0;
`ifdef WEIGHTED_RR_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef WEIGHTED_RR_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign pop_signal  = pop_q;
  assign push_signal = push_q;
  assign data_out    = data_q;
  assign grant       = grant_q;
  assign class_err   = err_q;

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// Bench for vc_rr_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
module tb_vc_rr_scheduler;
  localparam int LS = 12;
  localparam int BM = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    ae;
  logic [4*LS-1:0] din;
  logic          af;
  logic [3:0]    pop;
  logic          push;
  logic [LS-1:0] dout;
  logic [1:0]    gnt;
  logic          cerr;

  always #5 clk = ~clk;

  vc_rr_scheduler #(.LINE_SIZE(LS), .CLASS_BITS(2), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .almost_empty_signal(ae), .data_in(din),
    .almost_full_signal(af), .pop_signal(pop), .push_signal(push),
    .data_out(dout), .grant(gnt), .class_err(cerr)
  );

  int total = 0;
  int bad   = 0;

  // Model: each grant at edge n schedules a pop visible after edge n, a capture
  // at edge n+2 and the next possible grant at edge n+4.
  int          n = 0;
  int          free_at = 0;
  int          cap_at = -1;
  int          m_burst = 0;
  logic [1:0]  m_last = 2'd3;
  logic [1:0]  cap_src = 2'd0;
  logic [3:0]  e_pop = '0;
  logic        e_push = 1'b0;
  logic [LS-1:0] e_data = '0;
  logic [1:0]  e_grant = '0;
  logic        e_err = 1'b0;

  function automatic logic [LS-1:0] word_of(input logic [4*LS-1:0] d, input int i);
    return d[i*LS +: LS];
  endfunction

  task automatic model_step();
    logic [1:0] g;
    logic       held;
    if (reset) begin
      e_pop = '0; e_push = 1'b0; e_data = '0; e_grant = '0; e_err = 1'b0;
      m_last = 2'd3; m_burst = 0; free_at = n + 1; cap_at = -1;
    end else begin
      e_pop  = '0;
      e_push = 1'b0;
      if (n == cap_at) begin
        e_data = word_of(din, int'(cap_src));
        e_push = 1'b1;
        if (e_data[LS-1 -: 2] != cap_src) e_err = 1'b1;
      end
      if (n >= free_at && !af && ae != 4'hF) begin
        held = 1'b0;
        g = m_last;
`ifdef WEIGHTED_RR_EN
        if (m_burst > 0 && m_burst < BM && !ae[m_last]) begin
          held = 1'b1;
          m_burst++;
        end
`endif
        if (!held) begin
          for (int k = 4; k >= 1; k--)
            if (!ae[(int'(m_last) + k) % 4]) g = 2'((int'(m_last) + k) % 4);
          m_burst = 1;
        end
        e_pop = 4'b0001 << g; e_grant = g; m_last = g;
        cap_src = g; cap_at = n + 2; free_at = n + 4;
      end
    end
    n++;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ae = 4'hF; af = 1'b0; din = '0;
    tick();
    total++; if (pop !== 4'b0) begin bad++; $display("FAIL reset_pop got=%b want=0000", pop); end
    total++; if (push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b want=0", push); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_data got=%h want=000", dout); end
    total++; if (gnt !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", gnt); end
    total++; if (cerr !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cerr); end
    reset = 1'b0;
  endtask

  task automatic test_idle_empty();
    ae = 4'hF; af = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (pop !== 4'b0 || push !== 1'b0 || gnt !== 2'd0) begin
        bad++; $display("FAIL idle_empty cyc=%0d pop=%b push=%b grant=%0d want 0000/0/0", i, pop, push, gnt);
      end
    end
  endtask

  task automatic test_single_source();
    int pop_t, push_t;
    do_reset();
    ae = 4'b1011; af = 1'b0; din = '0; din[2*LS +: LS] = 12'h8A5;
    pop_t = -1; push_t = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pop_t >= 0 && i == pop_t + 1) begin
        total++; if (pop !== 4'b0) begin bad++; $display("FAIL single_pop_width got=%b want=0000", pop); end
      end
      if (pop_t < 0 && pop !== 4'b0) begin
        pop_t = i;
        total++; if (pop !== 4'b0100) begin bad++; $display("FAIL single_pop got=%b want=0100", pop); end
      end
      if (push_t < 0 && push === 1'b1) begin
        push_t = i;
        total++; if (dout !== 12'h8A5) begin bad++; $display("FAIL single_data got=%h want=8a5", dout); end
        total++; if (cerr !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", cerr); end
      end
    end
    total++; if (pop_t !== 0) begin bad++; $display("FAIL single_pop_time got=%0d want=0", pop_t); end
    total++; if (push_t !== pop_t + 2) begin bad++; $display("FAIL single_push_time got=%0d want=%0d", push_t, pop_t + 2); end
  endtask

  task automatic test_rr_order();
    int seq[$];
    int tms[$];
    int want[5];
`ifdef WEIGHTED_RR_EN
    want = '{0, 0, 1, 1, 2};
`else
    want = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    ae = 4'b0000; af = 1'b0;
    for (int i = 0; i < 4; i++) din[i*LS +: LS] = {2'(i), 10'($urandom)};
    for (int i = 0; i < 22; i++) begin
      tick();
      if (pop !== 4'b0) begin
        seq.push_back(int'(gnt)); tms.push_back(i);
        total++;
        if (pop !== (4'b0001 << gnt) || push === 1'b1) begin
          bad++; $display("FAIL rr_pop_shape pop=%b push=%b grant=%0d", pop, push, gnt);
        end
      end
    end
    total++;
    if (seq.size() < 5) begin
      bad++; $display("FAIL rr_count got=%0d want>=5", seq.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        total++; if (seq[j] != want[j]) begin bad++; $display("FAIL rr_seq idx=%0d got=%0d want=%0d", j, seq[j], want[j]); end
      end
      for (int j = 0; j < 4; j++) begin
        total++; if (tms[j+1] - tms[j] != 4) begin bad++; $display("FAIL rr_spacing idx=%0d got=%0d want=4", j, tms[j+1] - tms[j]); end
      end
    end
  endtask

  task automatic test_almost_full();
    logic seen;
    do_reset();
    ae = 4'b1110; af = 1'b0; din = '0; din[0 +: LS] = 12'h0AB;
    tick();
    total++; if (pop !== 4'b0001) begin bad++; $display("FAIL af_pop got=%b want=0001", pop); end
    tick();
    af = 1'b1;
    tick();
    total++; if (push !== 1'b1 || dout !== 12'h0AB) begin bad++; $display("FAIL af_push push=%b data=%h want 1/0ab", push, dout); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pop !== 4'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL af_block got=pop_seen want=no_pop"); end
    af = 1'b0;
    tick();
    total++; if (pop !== 4'b0001) begin bad++; $display("FAIL af_resume got=%b want=0001", pop); end
  endtask

  task automatic test_class_err();
    int push_t;
    do_reset();
    ae = 4'b1101; af = 1'b0; din = '0; din[LS +: LS] = 12'h3FF;
    push_t = -1;
    for (int i = 0; i < 8 && push_t < 0; i++) begin
      tick();
      if (push === 1'b1) push_t = i;
    end
    total++;
    if (push_t < 0) begin
      bad++; $display("FAIL cerr_push got=timeout want=push");
    end else if (dout !== 12'h3FF || cerr !== 1'b1 || gnt !== 2'd1) begin
      bad++; $display("FAIL cerr_push data=%h err=%b grant=%0d want 3ff/1/1", dout, cerr, gnt);
    end
    ae = 4'hF;
    for (int i = 0; i < 5; i++) tick();
    total++; if (cerr !== 1'b1) begin bad++; $display("FAIL cerr_sticky got=%b want=1", cerr); end
  endtask

  task automatic test_reset_mid_pop();
    logic seen;
    do_reset();
    ae = 4'b0000; af = 1'b0;
    for (int i = 0; i < 4; i++) din[i*LS +: LS] = {2'(i), 10'h155};
    tick();
    total++; if (pop === 4'b0) begin bad++; $display("FAIL midpop_pop got=%b want=nonzero", pop); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (pop !== 4'b0 || push !== 1'b0 || dout !== '0 || gnt !== 2'd0 || cerr !== 1'b0) begin
      bad++; $display("FAIL midpop_clear pop=%b push=%b data=%h grant=%0d err=%b want all 0", pop, push, dout, gnt, cerr);
    end
    ae = 4'hF; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (push !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midpop_nopush got=push_seen want=none"); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ae    = 4'($urandom_range(0, 15));
      af    = ($urandom_range(0, 3) == 0);
      din   = {16'($urandom), $urandom};
      reset = ($urandom_range(0, 79) == 0);
      tick();
      total++; if (pop !== e_pop) begin bad++; $display("FAIL rnd_pop cyc=%0d got=%b want=%b", i, pop, e_pop); end
      total++; if (push !== e_push) begin bad++; $display("FAIL rnd_push cyc=%0d got=%b want=%b", i, push, e_push); end
      total++; if (dout !== e_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, dout, e_data); end
      total++; if (gnt !== e_grant) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%0d want=%0d", i, gnt, e_grant); end
      total++; if (cerr !== e_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", i, cerr, e_err); end
      total++;
      if ($countones(pop) > 1 || (pop !== 4'b0 && push === 1'b1)) begin
        bad++; $display("FAIL rnd_exclusive cyc=%0d pop=%b push=%b", i, pop, push);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ae = 4'hF; af = 1'b0; din = '0;
    @(negedge clk);
    test_reset();
    test_idle_empty();
    test_single_source();
    test_rr_order();
    test_almost_full();
    test_class_err();
    test_reset_mid_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
